// File: rtl/e_md.sv
// E-stage multiply/divide unit: owns HI/LO, computes mult/div results up front
// and holds them in temp registers until a busy countdown expires.
//
// state  | meaning
// S_IDLE | counter is 0; accepts start, mthi/mtlo
// S_RUN  | counter > 0; result parked in hi/lo temp regs, commits on 1->0
module e_md #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        start,
  output logic        busy,
  output logic [31:0] mdResult
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]     r_hi, r_lo, r_hi_tmp, r_lo_tmp;
  logic            r_skip;

  logic w_mult, w_multu, w_div, w_divu, w_is_md, w_is_div, w_commit;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_abs_a, w_abs_b, w_q_mag, w_r_mag, w_q_s, w_r_s, w_q_u, w_r_u;
  logic [31:0] w_hi_res, w_lo_res;

  assign w_mult   = (mdOp == 4'd1);
  assign w_multu  = (mdOp == 4'd2);
  assign w_div    = (mdOp == 4'd3);
  assign w_divu   = (mdOp == 4'd4);
  assign w_is_md  = w_mult | w_multu | w_div | w_divu;
  assign w_is_div = w_div | w_divu;

  assign busy     = (r_state == S_RUN);
  assign start    = w_is_md & ~req & ~busy;
  assign w_commit = busy & (r_cnt == CW'(1));

  assign w_prod_s = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
  assign w_prod_u = {32'd0, srcA} * {32'd0, srcB};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign w_abs_a = srcA[31] ? -srcA : srcA;
  assign w_abs_b = srcB[31] ? -srcB : srcB;
  assign w_q_mag = w_abs_a / w_abs_b;
  assign w_r_mag = w_abs_a % w_abs_b;
  assign w_q_s   = (srcA[31] ^ srcB[31]) ? -w_q_mag : w_q_mag;
  assign w_r_s   = srcA[31] ? -w_r_mag : w_r_mag;
  assign w_q_u   = srcA / srcB;
  assign w_r_u   = srcA % srcB;

  always_comb begin
    w_hi_res = '0;
    w_lo_res = '0;
    if (w_mult) begin
      w_hi_res = w_prod_s[63:32];
      w_lo_res = w_prod_s[31:0];
    end else if (w_multu) begin
      w_hi_res = w_prod_u[63:32];
      w_lo_res = w_prod_u[31:0];
    end else if (w_div) begin
      w_hi_res = w_r_s;
      w_lo_res = w_q_s;
    end else if (w_divu) begin
      w_hi_res = w_r_u;
      w_lo_res = w_q_u;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt_nxt   = (w_mult | w_multu) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_hi_tmp <= '0;
      r_lo_tmp <= '0;
      r_skip   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (start) begin
        r_hi_tmp <= w_hi_res;
        r_lo_tmp <= w_lo_res;
        r_skip   <= w_is_div & (srcB == 32'd0);
      end
      // Commit only happens while busy and mthi/mtlo only while idle, so they never collide.
      if (w_commit) begin
        if (!r_skip) begin
          r_hi <= r_hi_tmp;
          r_lo <= r_lo_tmp;
        end
      end else if (!busy && !req) begin
        if (mdOp == 4'd7) r_hi <= srcA;
        if (mdOp == 4'd8) r_lo <= srcA;
      end
    end
  end

  always_comb begin
    mdResult = '0;
    if (mdOp == 4'd5)      mdResult = r_hi;
    else if (mdOp == 4'd6) mdResult = r_lo;
  end

endmodule

// File: tb/tb_e_md.sv
// Self-checking bench for e_md: directed scenarios plus randomized ops against
// a transaction-level HI/LO model using 64-bit arithmetic.
module tb_e_md;
  logic        clk, reset, req;
  logic [3:0]  mdOp;
  logic [31:0] srcA, srcB;
  logic        start, busy;
  logic [31:0] mdResult;

  e_md #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req), .mdOp(mdOp), .srcA(srcA), .srcB(srcB),
    .start(start), .busy(busy), .mdResult(mdResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_hi, m_lo, m_thi, m_tlo;
  int          m_cnt;
  bit          m_skip;

  logic        obs_start, obs_busy, exp_start, exp_busy;
  logic [31:0] obs_res, exp_res;

  function automatic void ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    longint unsigned pu;
    logic [63:0] v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      4'd1: begin p = sa * sb; v = p; hi = v[63:32]; lo = v[31:0]; end
      4'd2: begin pu = {32'd0, a} * {32'd0, b}; v = pu; hi = v[63:32]; lo = v[31:0]; end
      4'd3: begin q = sa / sb; r = sa % sb; v = q; lo = v[31:0]; v = r; hi = v[31:0]; end
      4'd4: begin lo = a / b; hi = a % b; end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_thi = 0; m_tlo = 0; m_cnt = 0; m_skip = 0;
  endtask

  // One clock: drive, sample combinational outputs, advance model at the edge.
  task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
    mdOp = op; srcA = a; srcB = b; req = rq;
    #1;
    obs_start = start; obs_busy = busy; obs_res = mdResult;
    exp_busy  = (m_cnt != 0);
    exp_start = (op >= 4'd1 && op <= 4'd4) && !rq && !exp_busy;
    exp_res   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    @(posedge clk);
    if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0 && !m_skip) begin m_hi = m_thi; m_lo = m_tlo; end
    end else if (!rq) begin
      if (op == 4'd7) m_hi = a;
      else if (op == 4'd8) m_lo = a;
      else if (op >= 4'd1 && op <= 4'd4) begin
        m_cnt  = (op <= 4'd2) ? 5 : 10;
        m_skip = (op >= 4'd3) && (b == 32'd0);
        if (!m_skip) ref_result(op, a, b, m_thi, m_tlo);
      end
    end
    #1;
  endtask

  // Issues mfhi until busy drops; obs_res then holds HI in the first idle cycle.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(4'd5, 32'd0, 32'd0, 1'b0);
      if (!obs_busy) break;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; mdOp = 4'd0; srcA = 0; srcB = 0;
    model_reset();
    #3 mdOp = 4'd5;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (mdResult !== 32'd0) begin n_errors++; $display("FAIL reset_hi: got %h exp 0", mdResult); end
    mdOp = 4'd6;
    #2;
    n_checks++; if (mdResult !== 32'd0) begin n_errors++; $display("FAIL reset_lo: got %h exp 0", mdResult); end
    #5 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int n;
    cyc(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    n_checks++; if (obs_start !== 1'b1) begin n_errors++; $display("FAIL mult_start: got %b exp 1", obs_start); end
    wait_idle(n);
    n_checks++; if (n != 5) begin n_errors++; $display("FAIL mult_busy_len: got %0d exp 5", n); end
    n_checks++; if (obs_res !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL mult_hi: got %h exp FFFFFFFF", obs_res); end
    cyc(4'd6, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'hFFFFFFFA) begin n_errors++; $display("FAIL mult_lo: got %h exp FFFFFFFA", obs_res); end
    cyc(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(n);
    n_checks++; if (n != 5) begin n_errors++; $display("FAIL multu_busy_len: got %0d exp 5", n); end
    n_checks++; if (obs_res !== 32'h00000002) begin n_errors++; $display("FAIL multu_hi: got %h exp 00000002", obs_res); end
    cyc(4'd6, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'hFFFFFFFA) begin n_errors++; $display("FAIL multu_lo: got %h exp FFFFFFFA", obs_res); end
  endtask

  task automatic test_div();
    int n;
    cyc(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(n);
    n_checks++; if (n != 10) begin n_errors++; $display("FAIL div_busy_len: got %0d exp 10", n); end
    n_checks++; if (obs_res !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL div_hi: got %h exp FFFFFFFF", obs_res); end
    cyc(4'd6, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'hFFFFFFFD) begin n_errors++; $display("FAIL div_lo: got %h exp FFFFFFFD", obs_res); end
    cyc(4'd7, 32'h11, 0, 1'b0);
    cyc(4'd8, 32'h22, 0, 1'b0);
    cyc(4'd4, 32'd7, 32'd0, 1'b0);
    wait_idle(n);
    n_checks++; if (n != 10) begin n_errors++; $display("FAIL divz_busy_len: got %0d exp 10", n); end
    n_checks++; if (obs_res !== 32'h11) begin n_errors++; $display("FAIL divz_hi: got %h exp 00000011", obs_res); end
    cyc(4'd6, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'h22) begin n_errors++; $display("FAIL divz_lo: got %h exp 00000022", obs_res); end
  endtask

  task automatic test_mthi_mtlo();
    int n;
    cyc(4'd7, 32'hDEADBEEF, 0, 1'b0);
    cyc(4'd5, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'hDEADBEEF) begin n_errors++; $display("FAIL mthi_read: got %h exp DEADBEEF", obs_res); end
    cyc(4'd8, 32'h0BADF00D, 0, 1'b0);
    cyc(4'd1, 32'd4, 32'd5, 1'b0);
    cyc(4'd8, 32'h12345678, 0, 1'b0);
    n_checks++; if (obs_busy !== 1'b1) begin n_errors++; $display("FAIL mtlo_busy: got %b exp 1", obs_busy); end
    cyc(4'd3, 32'd100, 32'd3, 1'b0);
    n_checks++; if (obs_start !== 1'b0) begin n_errors++; $display("FAIL start_while_busy: got %b exp 0", obs_start); end
    wait_idle(n);
    cyc(4'd6, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'd20) begin n_errors++; $display("FAIL mtlo_busy_lo: got %h exp 00000014", obs_res); end
  endtask

  task automatic test_req();
    int n;
    cyc(4'd7, 32'hAAAA0000, 0, 1'b0);
    cyc(4'd1, 32'd9, 32'd9, 1'b1);
    n_checks++; if (obs_start !== 1'b0) begin n_errors++; $display("FAIL req_start: got %b exp 0", obs_start); end
    cyc(4'd7, 32'h5555, 0, 1'b1);
    cyc(4'd5, 0, 0, 1'b0);
    n_checks++; if (obs_busy !== 1'b0) begin n_errors++; $display("FAIL req_busy: got %b exp 0", obs_busy); end
    n_checks++; if (obs_res !== 32'hAAAA0000) begin n_errors++; $display("FAIL req_hi: got %h exp AAAA0000", obs_res); end
    cyc(4'd1, 32'd6, 32'd7, 1'b0);
    cyc(4'd0, 0, 0, 1'b1);
    cyc(4'd0, 0, 0, 1'b1);
    wait_idle(n);
    n_checks++; if (n != 3) begin n_errors++; $display("FAIL req_run_len: got %0d exp 3", n); end
    cyc(4'd6, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'd42) begin n_errors++; $display("FAIL req_run_lo: got %h exp 0000002A", obs_res); end
  endtask

  task automatic test_overflow_back_to_back();
    int n;
    cyc(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(n);
    n_checks++; if (obs_res !== 32'd0) begin n_errors++; $display("FAIL ovf_hi: got %h exp 0", obs_res); end
    cyc(4'd6, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'h80000000) begin n_errors++; $display("FAIL ovf_lo: got %h exp 80000000", obs_res); end
    cyc(4'd1, 32'd3, 32'd5, 1'b0);
    for (int i = 0; i < 4; i++) cyc(4'd0, 0, 0, 1'b0);
    cyc(4'd1, 32'd10, 32'hFFFFFFFF, 1'b0);
    n_checks++; if (obs_busy !== 1'b1) begin n_errors++; $display("FAIL b2b_last_busy: got %b exp 1", obs_busy); end
    cyc(4'd1, 32'd10, 32'hFFFFFFFF, 1'b0);
    n_checks++; if (obs_start !== 1'b1 || obs_busy !== 1'b0) begin n_errors++; $display("FAIL b2b_start: got start=%b busy=%b exp 1/0", obs_start, obs_busy); end
    wait_idle(n);
    n_checks++; if (n != 5) begin n_errors++; $display("FAIL b2b_busy_len: got %0d exp 5", n); end
    cyc(4'd6, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'hFFFFFFF6) begin n_errors++; $display("FAIL b2b_lo: got %h exp FFFFFFF6", obs_res); end
  endtask

  task automatic test_reset_midrun();
    int n;
    cyc(4'd7, 32'h55, 0, 1'b0);
    cyc(4'd3, 32'd100, 32'd7, 1'b0);
    cyc(4'd0, 0, 0, 1'b0);
    cyc(4'd0, 0, 0, 1'b0);
    mdOp = 4'd5;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    n_checks++; if (mdResult !== 32'd0) begin n_errors++; $display("FAIL midrst_hi: got %h exp 0", mdResult); end
    model_reset();
    #4 reset = 1'b1;
    #3;
    wait_idle(n);
    for (int i = 0; i < 11; i++) cyc(4'd5, 0, 0, 1'b0);
    n_checks++; if (n != 0 || obs_busy !== 1'b0) begin n_errors++; $display("FAIL midrst_nocommit_busy: got n=%0d busy=%b exp 0", n, obs_busy); end
    n_checks++; if (obs_res !== 32'd0) begin n_errors++; $display("FAIL midrst_nocommit_hi: got %h exp 0", obs_res); end
    cyc(4'd6, 0, 0, 1'b0);
    n_checks++; if (obs_res !== 32'd0) begin n_errors++; $display("FAIL midrst_lo: got %h exp 0", obs_res); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    logic rq;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
      a  = pick();
      b  = pick();
      rq = ($urandom_range(0, 3) == 0);
      cyc(op, a, b, rq);
      n_checks++; if (obs_start !== exp_start) begin n_errors++; $display("FAIL rnd_start[%0d]: got %b exp %b", i, obs_start, exp_start); end
      n_checks++; if (obs_busy !== exp_busy) begin n_errors++; $display("FAIL rnd_busy[%0d]: got %b exp %b", i, obs_busy, exp_busy); end
      n_checks++; if (obs_res !== exp_res) begin n_errors++; $display("FAIL rnd_result[%0d] op=%0d: got %h exp %h", i, op, obs_res, exp_res); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_req();
    test_overflow_back_to_back();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, errors so far %0d", n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/e_md.md
Name: e_md

Overview:
- Multiply/divide unit in the E stage, alongside the ALU.
- Consumes the same forwarded srcA/srcB operands and owns the architectural HI/LO registers.
- Models MIPS mult/multu/div/divu latency with a busy counter; services mfhi/mflo/mthi/mtlo.
- mdResult is muxed with the ALU result into the E/M pipeline register. start/busy drive the D-stage stall logic.

Parameters:
MULT_CYCLES, 5, busy duration (cycles) for mult/multu
DIV_CYCLES, 10, busy duration (cycles) for div/divu

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  exception/interrupt flush request from M stage; suppresses state-changing ops this cycle
mdOp  input  4  operation: 0 nope, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others = nope
srcA  input  32  rs operand (forwarded)
srcB  input  32  rt operand (forwarded)
start  output  1  combinational; 1 when mdOp is 1..4, req=0, busy=0
busy  output  1  registered; 1 while an operation is in flight
mdResult  output  32  combinational; HI for mfhi, LO for mflo, else 0

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, temp result regs=0. Takes effect immediately and aborts any in-flight op; no HI/LO write follows.
- State: IDLE (counter=0) / RUN (counter>0); busy = (counter != 0).
- Start at edge T when start=1:
  - Compute the result into hi_tmp/lo_tmp at edge T.
  - Load counter = MULT_CYCLES or DIV_CYCLES; busy=1 from T through T+N-1.
- Each RUN edge decrements the counter. At the edge where the counter goes 1->0, commit HI<=hi_tmp and LO<=lo_tmp; busy falls the same edge.
  - New HI/LO is visible on mdResult in the first cycle busy=0.
- mult: signed 32x32 -> 64; HI=upper, LO=lower. multu: unsigned.
- div: signed; LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend. divu: unsigned.
  - 0x80000000 / 0xFFFFFFFF (signed) -> LO=0x80000000, HI=0.
- Divide by zero (srcB=0, div or divu): busy runs the full DIV_CYCLES, but HI/LO are left unchanged at commit.
- mthi/mtlo: write HI/LO from srcA at the next edge, only when busy=0 and req=0.
- mdOp 1..4 or 7..8 while busy=1: ignored; the in-flight op is unaffected. Upstream stall logic prevents this; the block still defines it.
- req=1: start forced to 0 and mthi/mtlo suppressed that cycle. An op already in RUN continues and commits normally.
- mfhi/mflo read the committed HI/LO only, never hi_tmp/lo_tmp. Reads while busy return the old values; upstream stalls these.
- mthi and a commit on the same edge cannot coincide, because mthi is blocked while busy.

Test Plan:
- reset=0 mid-run, 2 cycles after a div start -> busy=0 immediately; HI=LO=0; mfhi/mflo return 0 after release.
- mult srcA=0xFFFFFFFE (-2), srcB=3 -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div srcA=0xFFFFFFF9 (-7), srcB=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu srcA=7, srcB=0 with prior HI=0x11, LO=0x22 -> busy 10 cycles; HI/LO stay 0x11/0x22.
- mthi srcA=0xDEADBEEF, next-cycle mfhi -> mdResult=0xDEADBEEF. mtlo issued while busy=1 -> LO unchanged.
- mult issued with req=1 -> start=0, busy stays 0, HI/LO unchanged. req=1 asserted during an in-flight mult -> HI/LO still commit after 5 cycles.
- Overflow case div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Back-to-back: a mult issued the first cycle after busy drops -> accepted, busy re-asserts for 5 cycles.
